pll_reset_sequencer: RTL and testbench

Reset/lock supervisor that sits directly around the system PLL: drives the PLL's rst input, watches its locked output, and produces the staged resets for peripherals and CPU. Runs on the 50 MHz board reference clock, so it keeps running while the PLL output is stopped. Retries PLL reset on lock timeout, re-sequences on lock loss, and reports status.

---
 rtl/pll_seq_pkg.sv | 18 +
 rtl/sync_2ff.sv | 28 ++
 rtl/pll_reset_sequencer.sv | 143 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
//   pll_state_e : sequencer states, in bring-up order
//   CntWDefault : default state-counter width
//   RetryW      : width of the saturating lock-timeout retry counter
package pll_seq_pkg;

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StStable,
    StPeriph,
    StRun
  } pll_state_e;

  localparam int unsigned CntWDefault = 16;
  localparam int unsigned RetryW      = 4;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer with synchronous active-high reset.
//   clk_i : destination clock
//   rst_i : synchronous reset, clears both flops
//   d_i   : asynchronous input
//   q_o   : d_i delayed by two clk_i edges
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Reset/lock supervisor around the system PLL. Runs on the reference clock so it keeps
// sequencing while the PLL output is stopped.
//   refclk     : reference clock (only clock)
//   rst        : synchronous active-high reset
//   locked     : PLL lock, asynchronous, synchronized internally
//   sw_rst_req : single-cycle soft reset request (honoured in PERIPH and RUN)
//   pll_rst    : reset to the PLL
//   periph_rst : peripheral reset, active high
//   cpu_rst    : CPU reset, active high
//   ready      : high only in RUN
//   retry_cnt  : lock-timeout retries, saturating
//   lock_lost  : sticky flag, lock dropped after peripheral release
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT       = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES = 1000,
  parameter int unsigned CPU_DELAY_CYCLES   = 64,
  parameter int unsigned CNT_W              = CntWDefault
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              locked,
  input  logic              sw_rst_req,
  output logic              pll_rst,
  output logic              periph_rst,
  output logic              cpu_rst,
  output logic              ready,
  output logic [RetryW-1:0] retry_cnt,
  output logic              lock_lost
);

  // Counter value on the last cycle of each timed state.
  localparam logic [CNT_W-1:0] PllRstLast  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CpuLast     = CNT_W'(CPU_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);
  localparam logic [RetryW-1:0] RetryOne   = RetryW'(1);
  localparam logic [RetryW-1:0] RetryMax   = '1;

  pll_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              lost_q, lost_d;
  logic              locked_s;

  sync_2ff u_lock_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (locked),
    .q_o   (locked_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    unique case (state_q)
      StPllRst: begin
        if (cnt_q == PllRstLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (locked_s) begin
          state_d = StStable;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StPllRst;
          if (retry_q != RetryMax) retry_d = retry_q + RetryOne;
        end
      end
      StStable: begin
        // A dropout restarts the wait without counting as a retry.
        if (!locked_s) begin
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          state_d = StPeriph;
        end
      end
      StPeriph: begin
        if (!locked_s) begin
          state_d = StPllRst;
          lost_d  = 1'b1;
        end else if (sw_rst_req) begin
          state_d = StStable;
        end else if (cnt_q == CpuLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!locked_s) begin
          state_d = StPllRst;
          lost_d  = 1'b1;
        end else if (sw_rst_req) begin
          state_d = StStable;
        end
      end
      default: state_d = StPllRst;
    endcase
    // Counter restarts on every state change; RUN has no expiry so wrap there is harmless.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CntOne;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= StPllRst;
      cnt_q   <= '0;
      retry_q <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    pll_rst    = 1'b1;
    periph_rst = 1'b1;
    cpu_rst    = 1'b1;
    ready      = 1'b0;
    unique case (state_q)
      StPllRst: ;
      StWaitLock, StStable: pll_rst = 1'b0;
      StPeriph: begin
        pll_rst    = 1'b0;
        periph_rst = 1'b0;
      end
      StRun: begin
        pll_rst    = 1'b0;
        periph_rst = 1'b0;
        cpu_rst    = 1'b0;
        ready      = 1'b1;
      end
      default: ;
    endcase
  end

  assign retry_cnt = retry_q;
  assign lock_lost = lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: per-scenario stimulus with a table of expected output
// snapshots at given cycles, queued when a scenario starts and compared as cycles elapse.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       pll_rst, periph_rst, cpu_rst, ready, lock_lost;
  logic [3:0] retry_cnt;

  always #10 refclk = ~refclk;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT       (20),
    .LOCK_STABLE_CYCLES (8),
    .CPU_DELAY_CYCLES   (6),
    .CNT_W              (16)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked     (locked),
    .sw_rst_req (sw_rst_req),
    .pll_rst    (pll_rst),
    .periph_rst (periph_rst),
    .cpu_rst    (cpu_rst),
    .ready      (ready),
    .retry_cnt  (retry_cnt),
    .lock_lost  (lock_lost)
  );

  // outs = {pll_rst, periph_rst, cpu_rst, ready}
  typedef struct {
    int         scen;
    int         cyc;
    logic [3:0] outs;
    logic [3:0] retry;
    logic       lost;
  } chk_t;

  chk_t tbl[$];
  chk_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  function automatic void add(int s, int c, logic [3:0] o, logic [3:0] r, logic l);
    chk_t e;
    e.scen = s; e.cyc = c; e.outs = o; e.retry = r; e.lost = l;
    tbl.push_back(e);
  endfunction

  function automatic string scen_name(int s);
    case (s)
      0: return "bringup";
      1: return "timeout";
      2: return "glitch";
      3: return "lockloss";
      4: return "swrst";
      5: return "swrst_vs_loss";
      default: return "rst_in_periph";
    endcase
  endfunction

  // Inputs for scenario s during cycle c.
  task automatic stim(input int s, input int c, output logic lk, output logic sw,
                      output logic r);
    lk = 1'b0; sw = 1'b0; r = 1'b0;
    case (s)
      0: begin lk = (c >= 6); sw = (c == 10); end   // sw ignored in STABLE
      1: begin lk = 1'b0; sw = (c == 8); end        // sw ignored in WAIT_LOCK
      2: lk = (c >= 6) && (c != 10);
      3: lk = (c >= 6) && (c != 30) && (c != 31);
      4: begin lk = (c >= 6); sw = (c == 30); end
      5: begin lk = (c >= 6) && (c != 30) && (c != 31); sw = (c == 32); end
      default: begin lk = (c >= 30); r = (c == 43); end
    endcase
  endtask

  task automatic check_due(input int s);
    while (sb.size() != 0 && sb[0].cyc == cyc) begin
      chk_t e;
      e = sb.pop_front();
      checks++;
      if ({pll_rst, periph_rst, cpu_rst, ready} !== e.outs || retry_cnt !== e.retry ||
          lock_lost !== e.lost) begin
        errors++;
        $display("FAIL %s cyc %0d: got out=%b retry=%0d lost=%b, want out=%b retry=%0d lost=%b",
                 scen_name(s), cyc, {pll_rst, periph_rst, cpu_rst, ready}, retry_cnt,
                 lock_lost, e.outs, e.retry, e.lost);
      end
    end
  endtask

  task automatic run_scen(input int s, input int n);
    logic lk, sw, r;
    rst = 1'b1; locked = 1'b0; sw_rst_req = 1'b0;
    repeat (2) @(posedge refclk);
    #1;
    rst = 1'b0;
    cyc = 0;
    foreach (tbl[i]) if (tbl[i].scen == s) sb.push_back(tbl[i]);
    for (int c = 0; c < n; c++) begin
      stim(s, c, lk, sw, r);
      locked = lk; sw_rst_req = sw; rst = r;
      @(negedge refclk);
      check_due(s);
      @(posedge refclk);
      #1;
      cyc++;
    end
    if (sb.size() != 0) begin
      checks += sb.size();
      errors += sb.size();
      $display("FAIL %s: %0d expected snapshots never reached", scen_name(s), sb.size());
      sb.delete();
    end
  endtask

  initial begin
    // Normal bring-up
    add(0, 0, 4'b1110, 0, 0);  add(0, 3, 4'b1110, 0, 0);  add(0, 4, 4'b0110, 0, 0);
    add(0, 16, 4'b0110, 0, 0); add(0, 17, 4'b0010, 0, 0); add(0, 22, 4'b0010, 0, 0);
    add(0, 23, 4'b0001, 0, 0); add(0, 40, 4'b0001, 0, 0);
    // Lock timeout and retry saturation
    add(1, 4, 4'b0110, 0, 0);   add(1, 23, 4'b0110, 0, 0);  add(1, 24, 4'b1110, 1, 0);
    add(1, 27, 4'b1110, 1, 0);  add(1, 28, 4'b0110, 1, 0);  add(1, 47, 4'b0110, 1, 0);
    add(1, 48, 4'b1110, 2, 0);  add(1, 359, 4'b0110, 14, 0); add(1, 360, 4'b1110, 15, 0);
    add(1, 482, 4'b1110, 15, 0);
    // One-cycle glitch while STABLE
    add(2, 12, 4'b0110, 0, 0); add(2, 17, 4'b0110, 0, 0); add(2, 21, 4'b0110, 0, 0);
    add(2, 22, 4'b0010, 0, 0); add(2, 27, 4'b0010, 0, 0); add(2, 28, 4'b0001, 0, 0);
    // Lock loss in RUN, sticky flag survives re-lock
    add(3, 32, 4'b0001, 0, 0); add(3, 33, 4'b1110, 0, 1); add(3, 36, 4'b1110, 0, 1);
    add(3, 37, 4'b0110, 0, 1); add(3, 45, 4'b0110, 0, 1); add(3, 46, 4'b0010, 0, 1);
    add(3, 51, 4'b0010, 0, 1); add(3, 52, 4'b0001, 0, 1);
    // Soft reset in RUN keeps the PLL running
    add(4, 30, 4'b0001, 0, 0); add(4, 31, 4'b0110, 0, 0); add(4, 38, 4'b0110, 0, 0);
    add(4, 39, 4'b0010, 0, 0); add(4, 44, 4'b0010, 0, 0); add(4, 45, 4'b0001, 0, 0);
    // Soft reset coincident with lock loss: lock loss wins
    add(5, 32, 4'b0001, 0, 0); add(5, 33, 4'b1110, 0, 1);
    // rst pulse during PERIPH after one retry
    add(6, 24, 4'b1110, 1, 0); add(6, 40, 4'b0110, 1, 0); add(6, 41, 4'b0010, 1, 0);
    add(6, 43, 4'b0010, 1, 0); add(6, 44, 4'b1110, 0, 0); add(6, 47, 4'b1110, 0, 0);
    add(6, 48, 4'b0110, 0, 0);

    run_scen(0, 41);
    run_scen(1, 483);
    run_scen(2, 29);
    run_scen(3, 53);
    run_scen(4, 46);
    run_scen(5, 34);
    run_scen(6, 49);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
